// File: rtl/sample_io_ctrl.sv
// -----------------------------------------------------------------------------
// sample_io_ctrl
// Purpose: paces ADC samples into a small input FIFO at a programmable rate,
//          feeds the FIFO head to a processor on its read strobe, and captures
//          processor results for a DAC with a one-cycle valid strobe.
//
// Parameters
//   NUBITS  sample / data word width
//   FDEPTH  input FIFO depth in words (power of 2, >= 2)
//   DIVW    sample-period divider width
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      pulse: IDLE -> RUN (clears error flags)
//   stop       pulse: RUN -> IDLE (wins over start)
//   period     sample period in clocks minus 1 (sampled at divider reload)
//   adc_in     sample source
//   proc_in    FIFO head to processor (combinational; last popped when empty)
//   req_in     processor read strobe (pops one word)
//   proc_out   processor result
//   out_en     processor output enables, bit 0 captures proc_out
//   dac_out    captured result
//   dac_valid  one-cycle strobe for a new dac_out
//   running    high in RUN
//   level      FIFO occupancy
//   overrun    sticky: sample dropped on a full FIFO
//   underrun   sticky: read strobe on an empty FIFO
//
// Optional build macro IO_STATS_EN adds 32-bit counters:
//   n_in       accepted pushes
//   n_out      dac_valid strobes
// -----------------------------------------------------------------------------
module sample_io_ctrl #(
   parameter int unsigned NUBITS = 23,
   parameter int unsigned FDEPTH = 4,
   parameter int unsigned DIVW   = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            stop,
   input  logic        [DIVW-1:0]          period,
   input  logic signed [NUBITS-1:0]        adc_in,
   output logic signed [NUBITS-1:0]        proc_in,
   input  logic                            req_in,
   input  logic signed [NUBITS-1:0]        proc_out,
   input  logic        [1:0]               out_en,
   output logic signed [NUBITS-1:0]        dac_out,
   output logic                            dac_valid,
   output logic                            running,
   output logic        [$clog2(FDEPTH):0]  level,
   output logic                            overrun,
   output logic                            underrun
`ifdef IO_STATS_EN
   ,
   output logic        [31:0]              n_in,
   output logic        [31:0]              n_out
`endif
);

   localparam int unsigned AW = $clog2(FDEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     w_enter_run;

   logic [DIVW-1:0]          r_cnt;
   logic [DIVW-1:0]          r_per;
   logic                     w_tick;

   logic signed [NUBITS-1:0] r_mem [FDEPTH];
   logic [AW-1:0]            r_wptr;
   logic [AW-1:0]            r_rptr;
   logic [LW-1:0]            r_level;
   logic signed [NUBITS-1:0] r_last;
   logic                     w_empty;
   logic                     w_full;
   logic                     w_do_pop;
   logic                     w_do_push;

   logic signed [NUBITS-1:0] r_dac_out;
   logic                     r_dac_valid;
   logic                     r_overrun;
   logic                     r_underrun;

   logic                     w_unused_oen;

   // Next-state logic: stop has priority over start.
   always_comb begin
      w_state_nxt = r_state;
      w_enter_run = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_state_nxt = RUN;
               w_enter_run = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Sample tick fires on the cycle the divider reaches the latched period.
   assign w_tick = (r_state == RUN) && (r_cnt == r_per);

   // Divider; period is latched on RUN entry and at every reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_per <= '0;
      end else if (w_enter_run) begin
         r_cnt <= '0;
         r_per <= period;
      end else if (r_state == RUN) begin
         if (w_tick) begin
            r_cnt <= '0;
            r_per <= period;
         end else begin
            r_cnt <= r_cnt + DIVW'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == LW'(FDEPTH));
   assign w_do_pop  = req_in && !w_empty;
   assign w_do_push = w_tick && (!w_full || w_do_pop);

   // FIFO storage carries no reset; validity is tracked by the pointers/level.
   always_ff @(posedge clk) begin
      if (w_do_push && !rst) begin
         r_mem[r_wptr] <= adc_in;
      end
   end

   // FIFO pointers, occupancy and last-popped word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_last  <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
            r_last <= r_mem[r_rptr];
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Head of FIFO, or the most recently consumed word once drained.
   always_comb begin
      proc_in = r_last;
      if (!w_empty) begin
         proc_in = r_mem[r_rptr];
      end
   end

   // Sticky error flags; an error in the RUN-entry cycle is still recorded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_tick && w_full && !w_do_pop) begin
            r_overrun <= 1'b1;
         end else if (w_enter_run) begin
            r_overrun <= 1'b0;
         end
         if (req_in && w_empty) begin
            r_underrun <= 1'b1;
         end else if (w_enter_run) begin
            r_underrun <= 1'b0;
         end
      end
   end

   // DAC capture with a single-cycle valid strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dac_out   <= '0;
         r_dac_valid <= 1'b0;
      end else begin
         r_dac_valid <= out_en[0];
         if (out_en[0]) begin
            r_dac_out <= proc_out;
         end
      end
   end

   assign w_unused_oen = out_en[1];

`ifdef IO_STATS_EN
   logic [31:0] r_n_in;
   logic [31:0] r_n_out;

   // Free-running activity counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n_in  <= '0;
         r_n_out <= '0;
      end else begin
         if (w_do_push) begin
            r_n_in <= r_n_in + 32'(1);
         end
         if (out_en[0]) begin
            r_n_out <= r_n_out + 32'(1);
         end
      end
   end

   assign n_in  = r_n_in;
   assign n_out = r_n_out;
`endif

   assign dac_out   = r_dac_out;
   assign dac_valid = r_dac_valid;
   assign running   = (r_state == RUN);
   assign level     = r_level;
   assign overrun   = r_overrun;
   assign underrun  = r_underrun;

endmodule

// File: doc/sample_io_ctrl.md
SAMPLE_IO_CTRL -- requirements
Module: sample_io_ctrl

Interface
REQ-001 SHALL have parameter NUBITS, default 23: sample and data word width.
REQ-002 SHALL have parameter FDEPTH, default 4: input FIFO depth in words; power of 2, at least 2.
REQ-003 SHALL have parameter DIVW, default 16: sample-period divider width.
REQ-004 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle pulse requesting IDLE->RUN.
REQ-007 SHALL have port stop, input, 1: one-cycle pulse requesting RUN->IDLE.
REQ-008 SHALL have port period, input, DIVW: sample period in clocks, minus 1.
REQ-009 SHALL have port adc_in, input, signed NUBITS: sample source.
REQ-010 SHALL have port proc_in, output, signed NUBITS: drives the processor data input.
REQ-011 SHALL have port req_in, input, 1: processor input-read strobe.
REQ-012 SHALL have port proc_out, input, signed NUBITS: processor data output.
REQ-013 SHALL have port out_en, input, 2: decoded processor output enables; only bit 0 is used.
REQ-014 SHALL have port dac_out, output, signed NUBITS: captured filter result.
REQ-015 SHALL have port dac_valid, output, 1: one-cycle strobe marking a new dac_out.
REQ-016 SHALL have port running, output, 1: high in state RUN.
REQ-017 SHALL have port level, output, clog2(FDEPTH)+1: FIFO occupancy.
REQ-018 SHALL have ports overrun and underrun, output, 1 each: sticky error flags.

Function
REQ-019 SHALL implement two states, IDLE and RUN, encoded as follows:
- start in IDLE -> RUN;
- stop in RUN -> IDLE;
- start in RUN is ignored;
- start and stop in the same cycle: stop wins.
REQ-020 SHALL, in RUN, run the divider 0..period, assert an internal tick on the cycle count==period, then reload 0.
- period=0 gives a tick every cycle.
- period is sampled only at reload.
- The first tick occurs period+1 cycles after entering RUN.
REQ-021 SHALL, in IDLE, hold the divider at 0 and generate no ticks.
REQ-022 SHALL, on tick, push adc_in into the FIFO tail. If the FIFO is full and there is no simultaneous pop, the sample is dropped and overrun is set.
REQ-023 SHALL drive proc_in combinationally from the FIFO head when level>0. When empty, proc_in holds the last popped value (0 after reset).
REQ-024 SHALL handle req_in at the edge as follows:
- level>0: pop one word.
- level=0: no pop, underrun set.
- Pops are served in both IDLE and RUN (drain).
REQ-025 SHALL handle a simultaneous tick and req_in as follows:
- Non-empty FIFO: push and pop both occur, level unchanged; when full, no overrun.
- Empty FIFO: underrun set and the push completes, so level becomes 1.
REQ-026 SHALL wrap FIFO read and write pointers modulo FDEPTH.
REQ-027 SHALL, when out_en[0] is high at an edge, load dac_out <= proc_out and assert dac_valid for exactly the next cycle (latency 1).
- Back-to-back out_en[0] gives back-to-back dac_valid.
- out_en[1] is ignored.
REQ-028 SHALL clear overrun and underrun on the IDLE->RUN transition. The FIFO contents are not cleared on that transition.

Reset
REQ-029 SHALL, while rst is high at an edge, force the following, overriding start, stop, tick, req_in and out_en:
- state IDLE, divider 0;
- FIFO pointers 0, level 0;
- proc_in 0, dac_out 0, dac_valid 0, running 0;
- overrun 0, underrun 0.
REQ-030 SHALL, when rst is asserted mid-RUN, discard all queued samples. The first cycle after rst deasserts is IDLE.

Configuration
REQ-031 SHALL, with macro IO_STATS_EN defined, add two 32-bit outputs:
- n_in counts accepted pushes;
- n_out counts dac_valid strobes;
- both wrap at 2^32 and are cleared only by rst.
REQ-032 SHALL, with IO_STATS_EN undefined, omit n_in, n_out and their counters entirely. All other behaviour is identical.

Verification
REQ-033 SHALL cover: rst, then start with period=3, adc_in=5 -> first push 4 cycles after RUN entry, level=1, proc_in=5.
REQ-034 SHALL cover: FDEPTH=4, period=0, no req_in for 6 cycles -> level=4, overrun=1, then req_in x4 pops the first four samples in order.
REQ-035 SHALL cover: req_in with level=0 after proc_in=-7 -> underrun=1, proc_in stays -7, level stays 0.
REQ-036 SHALL cover: full FIFO, tick and req_in in the same cycle -> level stays 4, overrun stays 0.
REQ-037 SHALL cover: out_en=2'b01 with proc_out=-1000 -> next cycle dac_out=-1000 and dac_valid=1 for one cycle; out_en=2'b10 -> no dac_valid.
REQ-038 SHALL cover: rst pulse in RUN with level=3 -> next cycle level=0, running=0, proc_in=0; with IO_STATS_EN, n_in=0.
